// File: rtl/seq_addsub_cla_pkg.sv
// Shared definitions for the multi-cycle add/subtract engine: FSM state
// encoding, operation codes and the default slice width.
package seq_addsub_cla_pkg;

    // Bits handled per clock by the lookahead slice
    localparam int SLICE_W = 4;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Operation select carried on the 'sub' input
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/seq_addsub_cla_cla4_slice.sv
// Combinational SLICE-bit carry-lookahead adder: every internal carry and the
// carry out are built directly from generate/propagate terms and cin, so no
// carry ripples through a chain of sum cells.
module cla4_slice
    import seq_addsub_cla_pkg::*;
#(
    parameter int SLICE = SLICE_W
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin
        logic t_c;
        logic t_pp;
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            t_c  = w_g[i];
            t_pp = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                t_c  = t_c | (t_pp & w_g[j]);
                t_pp = t_pp & w_p[j];
            end
            w_c[i+1] = t_c | (t_pp & cin);
        end
    end

    assign s    = w_p ^ w_c[SLICE-1:0];
    assign cout = w_c[SLICE];

endmodule

// File: rtl/seq_addsub_cla.sv
// Multi-cycle WIDTH-bit adder/subtractor: one SLICE-bit lookahead slice is
// reused LSB-first, one nibble per clock, with the carry registered between
// slices. The committed result and flags only change when an operation
// completes, so they hold the previous answer while a new one is computed.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE and the
// outputs stay stable until out_ready is seen; in_valid is ignored outside IDLE.
module seq_addsub_cla
    import seq_addsub_cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = SLICE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;

    logic [IW-1:0]    w_base;
    logic [SLICE-1:0] w_sa;
    logic [SLICE-1:0] w_sb;
    logic [SLICE-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_next_acc;
    logic             w_ovf;

    assign w_base = IW'(r_cnt * SLICE);
    assign w_sa   = r_a[w_base +: SLICE];
    assign w_sb   = r_b[w_base +: SLICE];

    cla4_slice #(.SLICE(SLICE)) u_slice (
        .a    (w_sa),
        .b    (w_sb),
        .cin  (r_cin),
        .s    (w_sum),
        .cout (w_cout)
    );

    // Working result with the current slice merged in
    always_comb begin
        w_next_acc = r_acc;
        w_next_acc[w_base +: SLICE] = w_sum;
    end

    // Signed overflow: operands (b already inverted for sub) agree in sign but the top sum bit differs
    assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[SLICE-1] != r_a[WIDTH-1]);

    // FSM, slice counter, operand capture and result commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_cin      <= 1'b0;
            r_acc      <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_cin   <= (sub == OP_SUB);
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_next_acc;
                    r_cin <= w_cout;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_result   <= w_next_acc;
                        r_carry    <= w_cout;
                        r_overflow <= w_ovf;
                        r_zero     <= ~|w_next_acc;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_addsub_cla.sv
// Self-checking bench for seq_addsub_cla: directed corner cases, random
// operations, output backpressure and a reset abort mid-operation.
module tb_seq_addsub_cla;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    seq_addsub_cla #(.WIDTH(W), .SLICE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int           checks   = 0;
    int           failures = 0;
    logic [34:0]  exp_q[$];          // {result, carry, overflow, zero}
    logic [W-1:0] prev_result;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain 33-bit arithmetic
    task automatic push_expected(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic es);
        logic [W-1:0] bb;
        logic [W:0]   s;
        logic         v;
        bb = es ? ~eb : eb;
        s  = {1'b0, ea} + {1'b0, bb} + {{W{1'b0}}, es};
        v  = (ea[W-1] == bb[W-1]) && (s[W-1] != ea[W-1]);
        exp_q.push_back({s[W-1:0], s[W], v, (s[W-1:0] == '0)});
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_sub, input int hold);
        int          cyc;
        logic [34:0] e;
        @(negedge clk);
        check_eq("in_ready_idle", W'(in_ready), 1);
        a        = op_a;
        b        = op_b;
        sub      = op_sub;
        in_valid = 1'b1;
        push_expected(op_a, op_b, op_sub);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // operands changing after accept must not matter
        a   = $urandom;
        b   = $urandom;
        sub = 1'($urandom_range(0, 1));
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 4) begin
                check_eq("in_ready_busy", W'(in_ready), 0);
                check_eq("result_held_run", result, prev_result);
            end
        end
        if (!out_valid) begin
            check_eq("out_valid_timeout", W'(out_valid), 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        check_eq("latency", W'(cyc), 8);
        e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == 2);
            @(negedge clk);
            check_eq("held_out_valid", W'(out_valid), 1);
            check_eq("held_in_ready", W'(in_ready), 0);
            check_eq("held_result", result, e[34:3]);
        end
        in_valid = 1'b0;
        check_eq("result", result, e[34:3]);
        check_eq("carry", W'(carry), W'(e[2]));
        check_eq("overflow", W'(overflow), W'(e[1]));
        check_eq("zero", W'(zero), W'(e[0]));
        prev_result = e[34:3];
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("out_valid_drop", W'(out_valid), 0);
        check_eq("in_ready_back", W'(in_ready), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        sub         = 1'b0;
        prev_result = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", W'(in_ready), 1);
        check_eq("rst_out_valid", W'(out_valid), 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_flags", W'({carry, overflow, zero}), 0);
        check_eq("rst_state", W'(dbg_state), 0);
        rst_n = 1'b1;

        run_op(32'd5, 32'd3, 1'b1, 0);
        run_op(32'd3, 32'd5, 1'b1, 0);
        run_op(32'd7, 32'd7, 1'b1, 0);
        run_op(32'h8000_0000, 32'd1, 1'b1, 0);
        run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        for (int k = 0; k < 6; k++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 0);
        end

        // backpressure: 5 cycles with out_ready low, in_valid pulsed meanwhile
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5);

        // reset while the slice counter is at 3
        @(negedge clk);
        a        = 32'h1234_5678;
        b        = 32'h0F0F_0F0F;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("abort_state_run", W'(dbg_state), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_out_valid", W'(out_valid), 0);
        check_eq("abort_in_ready", W'(in_ready), 1);
        check_eq("abort_result", result, 0);
        check_eq("abort_carry", W'(carry), 0);
        @(negedge clk);
        rst_n       = 1'b1;
        prev_result = '0;
        @(negedge clk);
        check_eq("abort_no_emit", W'(out_valid), 0);
        run_op(32'd1, 32'd2, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
